// File: rtl/echo_ranger_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// echo_ranger_pkg : shared state encoding and default constants (rev 1.0)
// ---------------------------------------------------------------------------
package echo_ranger_pkg;

  localparam int DIST_W_DEF      = 9;
  localparam int CM_DIV_DEF      = 58;
  localparam int ARM_TO_US_DEF   = 30000;
  localparam int MAX_ECHO_US_DEF = 25000;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Bits needed for a counter that runs 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/echo_ranger_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// echo_ranger_if : trigger/echo inputs and distance/status outputs (rev 1.0)
// ---------------------------------------------------------------------------
interface echo_ranger_if
  import echo_ranger_pkg::*;
#(
  parameter int DIST_W = DIST_W_DEF
);
  logic              trig;
  logic              echo;
  logic [DIST_W-1:0] dist_cm;
  logic              dist_valid;
  logic              timeout;
  logic              busy;

  modport master (output trig, echo, input dist_cm, dist_valid, timeout, busy);
  modport slave  (input trig, echo, output dist_cm, dist_valid, timeout, busy);
endinterface
`default_nettype wire

// File: rtl/echo_ranger_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// echo_sync : 2-flop echo synchroniser with a history flop for edge pulses (rev 1.0)
// ---------------------------------------------------------------------------
module echo_sync
  import echo_ranger_pkg::*;
(
  input  logic clk_1m,
  input  logic rst_n,
  input  logic echo_raw,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [2:0] sync_q;

  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], echo_raw};
  end

  // level lags the edge pulses by one cycle, so the rise cycle is not
  // counted but the fall cycle is: the counted width equals the raw width.
  assign level = sync_q[2];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];
endmodule
`default_nettype wire

// File: rtl/echo_ranger.sv
`default_nettype none
// ---------------------------------------------------------------------------
// echo_ranger : trig-armed echo width to cm ranger; RANGE_AVG_EN adds 4-sample avg (rev 1.0)
// ---------------------------------------------------------------------------
module echo_ranger
  import echo_ranger_pkg::*;
#(
  parameter int DIST_W      = DIST_W_DEF,
  parameter int CM_DIV      = CM_DIV_DEF,
  parameter int ARM_TO_US   = ARM_TO_US_DEF,
  parameter int MAX_ECHO_US = MAX_ECHO_US_DEF
) (
  input  logic         clk_1m,
  input  logic         rst_n,
  echo_ranger_if.slave bus
);
  localparam int US_W  = cnt_width((ARM_TO_US > MAX_ECHO_US) ? ARM_TO_US : MAX_ECHO_US);
  localparam int SUB_W = cnt_width(CM_DIV);
  localparam logic [US_W-1:0]   ARM_LAST  = US_W'(ARM_TO_US - 1);
  localparam logic [US_W-1:0]   ECHO_LAST = US_W'(MAX_ECHO_US - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CM_DIV - 1);
  localparam logic [DIST_W-1:0] CM_MAX    = '1;

  logic              trig_q;
  logic              trig_fall;
  logic              echo_level;
  logic              echo_rise;
  logic              echo_fall;
  logic [1:0]        state;
  logic [US_W-1:0]   us_cnt;
  logic [SUB_W-1:0]  sub_cnt;
  logic [DIST_W-1:0] cm_cnt;

  echo_sync u_sync (
    .clk_1m   (clk_1m),
    .rst_n    (rst_n),
    .echo_raw (bus.echo),
    .level    (echo_level),
    .rise     (echo_rise),
    .fall     (echo_fall)
  );

  assign trig_fall = trig_q & ~bus.trig;
  assign bus.busy  = (state == ST_ARMED) || (state == ST_MEASURE);

  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) begin
      trig_q      <= 1'b0;
      state       <= ST_IDLE;
      us_cnt      <= '0;
      sub_cnt     <= '0;
      cm_cnt      <= '0;
      bus.timeout <= 1'b0;
    end else begin
      trig_q      <= bus.trig;
      bus.timeout <= 1'b0;
      // A new trigger wins over everything; DONE still publishes its result.
      if (trig_fall) begin
        state   <= ST_ARMED;
        us_cnt  <= '0;
        sub_cnt <= '0;
        cm_cnt  <= '0;
      end else begin
        case (state)
          ST_ARMED: begin
            if (echo_rise) begin
              state  <= ST_MEASURE;
              us_cnt <= '0;
            end else if (us_cnt == ARM_LAST) begin
              bus.timeout <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              us_cnt <= us_cnt + US_W'(1);
            end
          end
          ST_MEASURE: begin
            if (us_cnt == ECHO_LAST) begin
              bus.timeout <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              if (echo_level) begin
                us_cnt <= us_cnt + US_W'(1);
                if (sub_cnt == SUB_LAST) begin
                  sub_cnt <= '0;
                  if (cm_cnt != CM_MAX) cm_cnt <= cm_cnt + DIST_W'(1);
                end else begin
                  sub_cnt <= sub_cnt + SUB_W'(1);
                end
              end
              if (echo_fall) state <= ST_DONE;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef RANGE_AVG_EN
  logic [3:0][DIST_W-1:0] avg_buf;
  logic [2:0]             avg_fill;
  logic                   avg_pend;
  logic [DIST_W+1:0]      avg_sum;

  assign avg_sum = {2'b00, avg_buf[0]} + {2'b00, avg_buf[1]}
                 + {2'b00, avg_buf[2]} + {2'b00, avg_buf[3]};

  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) begin
      avg_buf        <= '0;
      avg_fill       <= '0;
      avg_pend       <= 1'b0;
      bus.dist_cm    <= '0;
      bus.dist_valid <= 1'b0;
    end else begin
      avg_pend       <= (state == ST_DONE);
      bus.dist_valid <= 1'b0;
      if (state == ST_DONE) begin
        avg_buf <= {avg_buf[2:0], cm_cnt};
        if (avg_fill != 3'd4) avg_fill <= avg_fill + 3'd1;
      end
      // Sum is taken one cycle after the shift so it includes the new sample.
      if (avg_pend && (avg_fill == 3'd4)) begin
        bus.dist_cm    <= avg_sum[DIST_W+1:2];
        bus.dist_valid <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) begin
      bus.dist_cm    <= '0;
      bus.dist_valid <= 1'b0;
    end else begin
      bus.dist_valid <= (state == ST_DONE);
      if (state == ST_DONE) bus.dist_cm <= cm_cnt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_echo_ranger.sv
`default_nettype none
`timescale 1ns/1ps
// tb_echo_ranger : directed and random echo widths checked against a cm/timeout reference model.
module tb_echo_ranger;
  localparam int DW     = 9;
  localparam int MAXD   = (1 << DW) - 1;
  localparam int CM     = 58;
`ifdef RANGE_AVG_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  echo_ranger_if #(.DIST_W(DW)) ifc ();
  echo_ranger #(.DIST_W(DW)) dut (.clk_1m(clk), .rst_n(rst_n), .bus(ifc.slave));

  always #500 clk = ~clk;

  int cyc = 0;
  int n_valid = 0, n_to = 0, valid_cyc = 0, to_cyc = 0;
  bit both_seen = 1'b0;
  int n_cmp = 0, n_fail = 0;
  int hist[$];
  int exp_dist = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (ifc.dist_valid === 1'b1) begin n_valid++; valid_cyc = cyc; end
    if (ifc.timeout === 1'b1) begin n_to++; to_cyc = cyc; end
    if (ifc.dist_valid === 1'b1 && ifc.timeout === 1'b1) both_seen = 1'b1;
  end

  // ---------------- stimulus helpers and reference model ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_trig();
    ifc.trig = 1'b1; tick(10); ifc.trig = 1'b0;
  endtask

  task automatic echo_pulse(input int width, output int fall_at);
    ifc.echo = 1'b1; tick(width); ifc.echo = 1'b0; fall_at = cyc;
  endtask

  function automatic int raw_cm(input int width);
    int c;
    c = width / CM;
    return (c > MAXD) ? MAXD : c;
  endfunction

  task automatic model_result(input int width, output bit v);
`ifdef RANGE_AVG_EN
    hist.push_back(raw_cm(width));
    if (hist.size() > 4) void'(hist.pop_front());
    v = (hist.size() == 4);
    if (v) exp_dist = (hist[0] + hist[1] + hist[2] + hist[3]) >> 2;
`else
    v = 1'b1;
    exp_dist = raw_cm(width);
`endif
  endtask

  task automatic measure(input int gap, input int width, output int f, output bit v);
    pulse_trig(); tick(gap); echo_pulse(width, f); tick(12);
    model_result(width, v);
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0; tick(n); rst_n = 1'b1;
    hist.delete(); exp_dist = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ifc.trig = 1'b0; ifc.echo = 1'b0; rst_n = 1'b0;
    tick(3);
    n_cmp++;
    if ({ifc.dist_cm, ifc.dist_valid, ifc.timeout, ifc.busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dist=%0d valid=%b timeout=%b busy=%b required all 0",
               ifc.dist_cm, ifc.dist_valid, ifc.timeout, ifc.busy);
    end
    rst_n = 1'b1; tick(2);
  endtask

  task automatic test_single();
    int nv, nt, f; bit v;
    nv = n_valid; nt = n_to;
    measure(100, 580, f, v);
    n_cmp++; if (n_valid - nv !== int'(v)) begin n_fail++; $display("FAIL single_valid_cnt: got %0d required %0d", n_valid - nv, v); end
    n_cmp++; if (ifc.dist_cm !== DW'(exp_dist)) begin n_fail++; $display("FAIL single_dist: got %0d required %0d", ifc.dist_cm, exp_dist); end
    if (v) begin
      n_cmp++; if (valid_cyc - f !== LAT) begin n_fail++; $display("FAIL single_latency: got %0d required %0d", valid_cyc - f, LAT); end
    end
    n_cmp++; if (n_to !== nt) begin n_fail++; $display("FAIL single_timeout: got %0d required 0", n_to - nt); end
  endtask

  task automatic test_arm_timeout();
    int nv, nt, f;
    nv = n_valid; nt = n_to;
    pulse_trig(); f = cyc; tick(5);
    n_cmp++; if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL arm_busy: got %b required 1", ifc.busy); end
    for (int i = 0; i < 30100 && n_to == nt; i++) tick(1);
    n_cmp++; if (n_to - nt !== 1) begin n_fail++; $display("FAIL arm_to_cnt: got %0d required 1", n_to - nt); end
    n_cmp++; if (to_cyc - f !== 30001) begin n_fail++; $display("FAIL arm_to_time: got %0d required 30001", to_cyc - f); end
    tick(2);
    n_cmp++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL arm_busy_drop: got %b required 0", ifc.busy); end
    n_cmp++; if (n_valid !== nv || ifc.dist_cm !== DW'(exp_dist)) begin
      n_fail++; $display("FAIL arm_dist_hold: got valid+%0d dist=%0d required valid+0 dist=%0d", n_valid - nv, ifc.dist_cm, exp_dist);
    end
  endtask

  task automatic test_echo_timeout();
    int nv, nt, r, f; bit v;
    nv = n_valid; nt = n_to;
    pulse_trig(); tick(20);
    ifc.echo = 1'b1; r = cyc; tick(25000); ifc.echo = 1'b0;
    tick(20);
    n_cmp++; if (n_to - nt !== 1) begin n_fail++; $display("FAIL echo_to_cnt: got %0d required 1", n_to - nt); end
    n_cmp++; if (to_cyc - r !== 25003) begin n_fail++; $display("FAIL echo_to_time: got %0d required 25003", to_cyc - r); end
    n_cmp++; if (n_valid !== nv || ifc.busy !== 1'b0 || ifc.dist_cm !== DW'(exp_dist)) begin
      n_fail++; $display("FAIL echo_to_state: got valid+%0d busy=%b dist=%0d required valid+0 busy=0 dist=%0d",
                         n_valid - nv, ifc.busy, ifc.dist_cm, exp_dist);
    end
    nv = n_valid; nt = n_to;
    measure(50, 1160, f, v);
    n_cmp++; if (n_valid - nv !== int'(v)) begin n_fail++; $display("FAIL echo_after_valid: got %0d required %0d", n_valid - nv, v); end
    n_cmp++; if (ifc.dist_cm !== DW'(exp_dist)) begin n_fail++; $display("FAIL echo_after_dist: got %0d required %0d", ifc.dist_cm, exp_dist); end
  endtask

  task automatic test_reset_mid();
    int nv, f; bit v;
    pulse_trig(); tick(30); ifc.echo = 1'b1; tick(200);
    rst_n = 1'b0; #1;
    n_cmp++;
    if ({ifc.dist_cm, ifc.dist_valid, ifc.timeout, ifc.busy} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got dist=%0d valid=%b timeout=%b busy=%b required all 0",
                         ifc.dist_cm, ifc.dist_valid, ifc.timeout, ifc.busy);
    end
    hist.delete(); exp_dist = 0;
    tick(3); rst_n = 1'b1; ifc.echo = 1'b0; tick(5);
    nv = n_valid;
    measure(60, 870, f, v);
    n_cmp++; if (n_valid - nv !== int'(v) || ifc.dist_cm !== DW'(exp_dist)) begin
      n_fail++; $display("FAIL midreset_remeasure: got valid+%0d dist=%0d required valid+%0d dist=%0d", n_valid - nv, ifc.dist_cm, v, exp_dist);
    end
  endtask

  task automatic test_retrigger();
    int nv, nt, f; bit v;
    nv = n_valid; nt = n_to;
    pulse_trig(); tick(50); ifc.echo = 1'b1; tick(200);
    pulse_trig(); tick(20); ifc.echo = 1'b0; tick(30);
    echo_pulse(290, f); tick(12);
    model_result(290, v);
    n_cmp++; if (n_valid - nv !== int'(v)) begin n_fail++; $display("FAIL retrig_valid_cnt: got %0d required %0d", n_valid - nv, v); end
    n_cmp++; if (ifc.dist_cm !== DW'(exp_dist)) begin n_fail++; $display("FAIL retrig_dist: got %0d required %0d", ifc.dist_cm, exp_dist); end
    n_cmp++; if (n_to !== nt) begin n_fail++; $display("FAIL retrig_timeout: got %0d required 0", n_to - nt); end
  endtask

  task automatic test_back_to_back();
    int nv, nt, f; bit v;
    nv = n_valid; nt = n_to;
    pulse_trig(); tick(40);
    ifc.echo = 1'b1; tick(860); ifc.trig = 1'b1; tick(10);
    ifc.echo = 1'b0; f = cyc; tick(3);
    ifc.trig = 1'b0;                       // falls while the result is being published
    model_result(870, v); tick(6);
    n_cmp++; if (n_valid - nv !== int'(v) || ifc.dist_cm !== DW'(exp_dist)) begin
      n_fail++; $display("FAIL b2b_first: got valid+%0d dist=%0d required valid+%0d dist=%0d", n_valid - nv, ifc.dist_cm, v, exp_dist);
    end
    n_cmp++; if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_rearmed: got busy=%b required 1", ifc.busy); end
    nv = n_valid;
    tick(30); echo_pulse(116, f); tick(12); model_result(116, v);
    n_cmp++; if (n_valid - nv !== int'(v) || ifc.dist_cm !== DW'(exp_dist) || n_to !== nt) begin
      n_fail++; $display("FAIL b2b_second: got valid+%0d dist=%0d to+%0d required valid+%0d dist=%0d to+0",
                         n_valid - nv, ifc.dist_cm, n_to - nt, v, exp_dist);
    end
  endtask

  task automatic test_random();
    int nv, nt, f, w, g; bit v;
    for (int i = 0; i < 10; i++) begin
      g = $urandom_range(150, 1);
      case (i % 3)
        0:       w = CM * $urandom_range(20, 1);
        1:       w = CM * $urandom_range(20, 1) - 1;
        default: w = $urandom_range(1200, 1);
      endcase
      nv = n_valid; nt = n_to;
      measure(g, w, f, v);
      n_cmp++; if (n_valid - nv !== int'(v) || ifc.dist_cm !== DW'(exp_dist)) begin
        n_fail++; $display("FAIL rand_w%0d: got valid+%0d dist=%0d required valid+%0d dist=%0d", w, n_valid - nv, ifc.dist_cm, v, exp_dist);
      end
      if (v) begin
        n_cmp++; if (valid_cyc - f !== LAT) begin n_fail++; $display("FAIL rand_latency_w%0d: got %0d required %0d", w, valid_cyc - f, LAT); end
      end
      n_cmp++; if (n_to !== nt) begin n_fail++; $display("FAIL rand_timeout_w%0d: got %0d required 0", w, n_to - nt); end
    end
  endtask

  task automatic test_sequence();
    int widths[4] = '{580, 1160, 1740, 2378};
    int nv, f; bit v;
    apply_reset(3); tick(2);
    for (int i = 0; i < 4; i++) begin
      nv = n_valid;
      measure(40, widths[i], f, v);
      n_cmp++; if (n_valid - nv !== int'(v) || ifc.dist_cm !== DW'(exp_dist)) begin
        n_fail++; $display("FAIL seq_%0d: got valid+%0d dist=%0d required valid+%0d dist=%0d", i, n_valid - nv, ifc.dist_cm, v, exp_dist);
      end
    end
  endtask

  initial begin
    ifc.trig = 1'b0;
    ifc.echo = 1'b0;
    test_reset();
    test_single();
    test_arm_timeout();
    test_echo_timeout();
    test_reset_mid();
    test_retrigger();
    test_back_to_back();
    test_random();
    test_sequence();
    n_cmp++; if (both_seen !== 1'b0) begin n_fail++; $display("FAIL valid_timeout_overlap: got 1 required 0"); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
